cmd_mode_flags: RTL
===================

Name: cmd_mode_flags

Overview:
Parametrised mode-flag controller driven by the host command byte stream (UART RX path). It holds NUM_FLAGS independent mode bits; flag 0 is the character-echo enable. Each flag has its own set/clear character. Two further commands are supported: a two-byte bulk write ('#' + argument byte) and a status query ('?') that returns the flag vector over a valid/ready reply channel to the TX path.

Parameters:
NUM_FLAGS, 4, number of mode flags (legal range 1..8).
SET_CHARS, {"G","T","L","E"}, 8*NUM_FLAGS packed; byte i is the set character for flag i.
CLR_CHARS, {"g","t","l","e"}, 8*NUM_FLAGS packed; byte i is the clear character for flag i.
FLAG_INIT, 4'b0001, flag values after reset (echo on, all other flags off).
WRITE_CHAR, 8'd35 ('#'), bulk-write prefix.
QUERY_CHAR, 8'd63 ('?'), status query.
ARG_TIMEOUT, 16'd50000, cycles to wait for the bulk-write argument byte; must be >= 1.

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high
Cmd  in  8  command byte
CmdValid  in  1  Cmd is valid this cycle
CmdReady  out  1  block can accept a byte; combinational from state
Flags  out  NUM_FLAGS  current mode flags; registered; Flags[0] is EchoChar
ReplyData  out  8  query reply: {zero-pad, Flags}
ReplyValid  out  1  reply is available
ReplyReady  in  1  TX path accepts the reply
CmdError  out  1  one-cycle pulse on a bad argument or an argument timeout

Behaviour:
- Reset (Clock edge with Reset=1): state=IDLE, Flags=FLAG_INIT, ReplyData=0, ReplyValid=0, CmdError=0, timeout counter=0. CmdReady=1 from the following cycle.
- Reset has priority over every other event. Reset during REPLY discards the pending reply. Reset during ARG discards the pending write.
- A byte is accepted only on a cycle where CmdValid && CmdReady. When CmdReady=0, CmdValid is ignored and the byte is not consumed.
- States: IDLE, ARG, REPLY. 2-bit encoding; IDLE=0.
- IDLE, accepted byte:
  - Matches SET_CHARS[i]: Flags[i] is set on the next edge.
  - Matches CLR_CHARS[i]: Flags[i] is cleared on the next edge.
  - Match evaluation is per flag and independent, so one byte may affect several flags.
  - If one byte matches both the set and clear character of the same flag, set wins.
  - Equals QUERY_CHAR: ReplyData<=zero-extended Flags; go to REPLY.
  - Equals WRITE_CHAR: counter<=ARG_TIMEOUT; go to ARG.
  - QUERY_CHAR and WRITE_CHAR take priority over set/clear matches.
  - Any other byte is ignored silently; no error.
- ARG:
  - CmdReady=1. The counter decrements by 1 each cycle in which no byte is accepted.
  - Byte accepted with Cmd[7:NUM_FLAGS]==0: Flags<=Cmd[NUM_FLAGS-1:0]; go to IDLE.
  - Byte accepted with nonzero upper bits: Flags unchanged; CmdError=1 for one cycle; go to IDLE.
  - No byte and counter==1: CmdError pulse; go to IDLE; Flags unchanged.
  - Byte accepted on the same cycle the counter would expire: the byte wins.
  - When NUM_FLAGS=8 the upper-bit check is vacuous.
- REPLY:
  - ReplyValid=1, CmdReady=0; ReplyData held stable.
  - On ReplyValid && ReplyReady: ReplyValid<=0; go to IDLE; CmdReady=1 on the next cycle.
- Latencies:
  - Flag change visible 1 cycle after acceptance.
  - ReplyValid asserted 1 cycle after query acceptance.
  - Minimum query turnaround is 2 cycles (accept, then reply handshake).
- CmdError is a registered single-cycle pulse; never asserted for two consecutive cycles.
- Flags change only in IDLE (set/clear) or ARG (bulk write).

Decomposition:
- Shared package cmd_pkg holds:
  - state encoding: ST_IDLE, ST_ARG, ST_REPLY;
  - the character constants: CH_WRITE, CH_QUERY, CH_ECHO_ON ('E'=69), CH_ECHO_OFF ('e'=101);
  - the flag index FLAG_ECHO=0.
- One sub-module: cmd_arg_timer, a 16-bit loadable down-counter.
  - Ports: load, run, expire.
  - Instantiated once.

Test Plan:
1. Reset, then send 'e' (101) -> Flags=4'b0000 one cycle later; send 'E' (69) -> Flags=4'b0001; unknown byte 'x' -> Flags unchanged, CmdError=0.
2. Send 'L', 'T', then '?' with ReplyReady=0 for 5 cycles -> ReplyValid held and CmdReady=0 throughout, ReplyData=8'h07. Raise ReplyReady -> ReplyValid=0 next cycle, CmdReady=1.
3. '#' then 8'h0A -> Flags=4'b1010. '#' then 8'h1A -> CmdError single pulse, Flags stays 4'b1010.
4. '#' with ARG_TIMEOUT=16 overridden, no further bytes -> CmdError pulses; state returns to IDLE; Flags unchanged; a following 'E' is processed normally.
5. Assert Reset while in REPLY and again 2 cycles after '#' -> ReplyValid=0, Flags=4'b0001, CmdReady=1, no CmdError.
6. CmdValid held high with 'g' while CmdReady=0 (REPLY) -> byte not consumed. After the handshake, 'g' is accepted exactly once: Flags[3] cleared.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the command-byte mode-flag controller:
// FSM state encoding, command characters and well-known flag indices.
package cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARG   = 2'd1,
    ST_REPLY = 2'd2
  } state_t;

  localparam logic [7:0] CH_WRITE    = 8'd35;
  localparam logic [7:0] CH_QUERY    = 8'd63;
  localparam logic [7:0] CH_ECHO_ON  = 8'd69;
  localparam logic [7:0] CH_ECHO_OFF = 8'd101;

  localparam int FLAG_ECHO = 0;

endpackage

// File: rtl/cmd_arg_timer.sv
// Loadable 16-bit down-counter that bounds how long a bulk write waits for its argument.
// expire is raised on the last counted cycle, while run is still asserted.
module cmd_arg_timer
  import cmd_pkg::*;
#(
  parameter logic [15:0] INIT = 16'd50000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic load,
  input  logic run,
  output logic expire
);

  logic [15:0] count;

  always_ff @(posedge Clock) begin
    if (Reset)
      count <= 16'd0;
    else if (load)
      count <= INIT;
    else if (run && count != 16'd0)
      count <= count - 16'd1;
  end

  assign expire = run && (count == 16'd1);

endmodule

// File: rtl/cmd_mode_flags.sv
// Mode-flag controller fed by the host command byte stream: per-flag set/clear
// characters, a '#'+argument bulk write and a '?' status query with a reply handshake.
module cmd_mode_flags
  import cmd_pkg::*;
#(
  parameter int                     NUM_FLAGS   = 4,
  parameter logic [8*NUM_FLAGS-1:0] SET_CHARS   = {"G", "T", "L", CH_ECHO_ON},
  parameter logic [8*NUM_FLAGS-1:0] CLR_CHARS   = {"g", "t", "l", CH_ECHO_OFF},
  parameter logic [NUM_FLAGS-1:0]   FLAG_INIT   = NUM_FLAGS'(1 << FLAG_ECHO),
  parameter logic [7:0]             WRITE_CHAR  = CH_WRITE,
  parameter logic [7:0]             QUERY_CHAR  = CH_QUERY,
  parameter logic [15:0]            ARG_TIMEOUT = 16'd50000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [7:0]           Cmd,
  input  logic                 CmdValid,
  output logic                 CmdReady,
  output logic [NUM_FLAGS-1:0] Flags,
  output logic [7:0]           ReplyData,
  output logic                 ReplyValid,
  input  logic                 ReplyReady,
  output logic                 CmdError
);

  state_t state, nextState;

  logic                 accept;
  logic                 isQuery;
  logic                 isWrite;
  logic                 argBad;
  logic                 timerLoad;
  logic                 timerRun;
  logic                 timerExpire;
  logic                 errNext;
  logic [NUM_FLAGS-1:0] flagsNext;
  logic [7:0]           flagsPadded;

  // Acceptance is derived from state directly so it does not loop through CmdReady.
  assign accept  = CmdValid && (state != ST_REPLY);
  assign isQuery = (Cmd == QUERY_CHAR);
  assign isWrite = (Cmd == WRITE_CHAR);
  assign argBad  = (Cmd >> NUM_FLAGS) != 8'd0;

  always_ff @(posedge Clock) begin
    if (Reset)
      state <= ST_IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (accept && isQuery)
          nextState = ST_REPLY;
        else if (accept && isWrite)
          nextState = ST_ARG;
      end
      ST_ARG: begin
        if (accept || timerExpire)
          nextState = ST_IDLE;
      end
      ST_REPLY: begin
        if (ReplyReady)
          nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Set/clear matches are evaluated per flag; set is tested first so it wins a tie.
  always_comb begin
    CmdReady    = (state != ST_REPLY);
    timerLoad   = (state == ST_IDLE) && accept && !isQuery && isWrite;
    timerRun    = (state == ST_ARG) && !accept;
    flagsNext   = Flags;
    errNext     = 1'b0;
    flagsPadded = 8'd0;
    flagsPadded[NUM_FLAGS-1:0] = Flags;
    case (state)
      ST_IDLE: begin
        if (accept && !isQuery && !isWrite) begin
          for (int i = 0; i < NUM_FLAGS; i++) begin
            if (Cmd == SET_CHARS[8*i +: 8])
              flagsNext[i] = 1'b1;
            else if (Cmd == CLR_CHARS[8*i +: 8])
              flagsNext[i] = 1'b0;
          end
        end
      end
      ST_ARG: begin
        if (accept) begin
          if (argBad)
            errNext = 1'b1;
          else
            flagsNext = Cmd[NUM_FLAGS-1:0];
        end else if (timerExpire) begin
          errNext = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Flags      <= FLAG_INIT;
      ReplyData  <= 8'd0;
      ReplyValid <= 1'b0;
      CmdError   <= 1'b0;
    end else begin
      Flags      <= flagsNext;
      CmdError   <= errNext;
      ReplyValid <= (nextState == ST_REPLY);
      if (state == ST_IDLE && nextState == ST_REPLY)
        ReplyData <= flagsPadded;
    end
  end

  cmd_arg_timer #(
    .INIT(ARG_TIMEOUT)
  ) argTimer (
    .Clock (Clock),
    .Reset (Reset),
    .load  (timerLoad),
    .run   (timerRun),
    .expire(timerExpire)
  );

endmodule
